anim_sequencer: RTL and testbench
=================================

ANIM_SEQUENCER -- requirements
Module: anim_sequencer

Interface
REQ-001 Parameters (name, default, meaning): T_ATK_START 5 / T_ATK_END 2 / T_ATK_PULL 8, frame ticks per attack phase; T_DIR_START 4 / T_DIR_END 3 / T_DIR_PULL 10, frame ticks per directional-attack phase; T_HIT 15, ticks in GOTHIT; T_BLOCK 10, ticks in BLOCK; all 1..31.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 frame_tick  in  1  one-cycle pulse once per video frame (end of active area).
REQ-005 game_state  in  3  game state; 3'd2 = FIGHT, any other value = not fighting.
REQ-006 act_fwd, act_back, act_attack, act_dir, act_block  in  1 each  player request levels.
REQ-007 block_avail  in  1  player has at least one block charge left.
REQ-008 got_hit  in  1  one-cycle pulse, opponent hit landed on this player; may arrive in any cycle.
REQ-009 sprite_state  out  4  sprite code to renderer: 0 IDLE, 1 WALK, 2 WALKBACK, 3 ATK_START, 4 ATK_END, 5 ATK_PULL, 6 DIR_START, 7 DIR_END, 8 DIR_PULL, 9 GOTHIT, 10 BLOCK.
REQ-010 hit_window  out  1  high while sprite_state is 4 or 7.
REQ-011 busy  out  1  high while in any timed state (3..10).
REQ-012 block_used  out  1  one-cycle pulse on entry to BLOCK.
REQ-013 hit_blocked  out  1  one-cycle pulse when a pending hit is absorbed in BLOCK.

Function
REQ-014 All outputs SHALL be registered; sprite_state, hit_window, busy SHALL change only in the cycle after a clk edge that samples frame_tick=1 (so the sprite never changes mid-frame).
REQ-015 got_hit SHALL set a pending flag held until the next sampled frame_tick; got_hit coincident with frame_tick SHALL be acted on at that tick.
REQ-016 On each tick, priority SHALL be: (a) game_state!=FIGHT -> IDLE, counter 0, pending cleared; (b) pending hit and state!=BLOCK -> GOTHIT, pending cleared; (c) pending hit in BLOCK -> stay BLOCK, pending cleared, hit_blocked pulse; (d) timed-state countdown; (e) untimed selection.
REQ-017 Timed-state entry SHALL load counter with T-1; each tick: counter!=0 -> decrement, counter==0 -> advance; each timed state SHALL last exactly T ticks.
REQ-018 Advance order: ATK_START->ATK_END->ATK_PULL->untimed selection; DIR_START->DIR_END->DIR_PULL->untimed selection; GOTHIT->untimed selection; BLOCK->untimed selection.
REQ-019 Untimed selection (from IDLE/WALK/WALKBACK or on timed-state exit) SHALL choose first true of: act_attack->ATK_START; act_dir->DIR_START; act_block&block_avail->BLOCK; act_fwd&!act_back->WALK; act_back&!act_fwd->WALKBACK; else IDLE.
REQ-020 act_block with block_avail=0 SHALL be ignored (falls through to movement).
REQ-021 Requests during timed states SHALL not be queued; only levels at the selecting tick count.
REQ-022 GOTHIT SHALL preempt any attack phase, including ATK_END/DIR_END, and restart if hit again during GOTHIT (counter reloaded to T_HIT-1).
REQ-023 block_used SHALL pulse in the same cycle sprite_state becomes 10; not on BLOCK re-selection without leaving (n/a: BLOCK always exits via selection first).
REQ-024 Counter SHALL be 5 bits; no wrap below zero.

Reset
REQ-025 On rst: sprite_state=0, counter=0, pending=0, hit_window=0, busy=0, block_used=0, hit_blocked=0, immediately and regardless of clk.
REQ-026 Reset mid-attack SHALL abandon the sequence; first tick after release SHALL perform untimed selection.

Verification
REQ-027 FIGHT, act_attack held one tick then released, defaults -> states 3 x5 ticks, 4 x2 (hit_window=1), 5 x8, then 0; busy high for 15 ticks.
REQ-028 In ATK_START, got_hit pulse 10 cycles before a tick -> at that tick state 9, held 15 ticks, then 0; hit_window never asserted.
REQ-029 act_block=1, block_avail=1, then got_hit during BLOCK -> block_used pulse on entry, hit_blocked pulse at next tick, state stays 10 for 10 ticks total.
REQ-030 act_block=1, block_avail=0, act_fwd=1 -> state 1, no block_used; act_fwd=act_back=1 -> state 0.
REQ-031 During DIR_END, game_state changes to 3 (P1_WIN) -> next tick state 0, busy 0; act_* ignored until game_state returns to 2.
REQ-032 rst asserted mid-GOTHIT between ticks -> all outputs 0 within the same cycle; no transition without frame_tick.

Source files
------------

// File: rtl/anim_sequencer.sv
// ---------------------------------------------------------------------------
// anim_sequencer
//
// Purpose:
//    Per-player animation state machine for the fighting game. It picks the
//    sprite code the renderer draws. Changes happen only on frame ticks, so
//    the sprite never switches partway through a frame. Timed states (attack
//    phases, hit stun and block) count frame ticks. Untimed states (idle and
//    walking) re-read the player's request levels on every tick.
//
// Ports:
//    clk            in   sole clock, rising edge
//    rst            in   asynchronous active-high reset
//    frame_tick     in   one-cycle pulse per video frame
//    game_state     in   [2:0] game state, 3'd2 means FIGHT
//    act_fwd        in   walk-forward request level
//    act_back       in   walk-back request level
//    act_attack     in   attack request level
//    act_dir        in   directional-attack request level
//    act_block      in   block request level
//    block_avail    in   at least one block charge remains
//    got_hit        in   one-cycle pulse, the opponent landed a hit
//    sprite_state   out  [3:0] sprite code (0 IDLE .. 10 BLOCK)
//    hit_window     out  high during ATK_END / DIR_END
//    busy           out  high during any timed state (codes 3..10)
//    block_used     out  one-cycle pulse on entry to BLOCK
//    hit_blocked    out  one-cycle pulse when BLOCK absorbs a pending hit
// ---------------------------------------------------------------------------
module anim_sequencer #(
   parameter int T_ATK_START = 5,
   parameter int T_ATK_END   = 2,
   parameter int T_ATK_PULL  = 8,
   parameter int T_DIR_START = 4,
   parameter int T_DIR_END   = 3,
   parameter int T_DIR_PULL  = 10,
   parameter int T_HIT       = 15,
   parameter int T_BLOCK     = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic [2:0] game_state,
   input  logic       act_fwd,
   input  logic       act_back,
   input  logic       act_attack,
   input  logic       act_dir,
   input  logic       act_block,
   input  logic       block_avail,
   input  logic       got_hit,
   output logic [3:0] sprite_state,
   output logic       hit_window,
   output logic       busy,
   output logic       block_used,
   output logic       hit_blocked
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_WALK      = 4'd1,
      S_WALKBACK  = 4'd2,
      S_ATK_START = 4'd3,
      S_ATK_END   = 4'd4,
      S_ATK_PULL  = 4'd5,
      S_DIR_START = 4'd6,
      S_DIR_END   = 4'd7,
      S_DIR_PULL  = 4'd8,
      S_GOTHIT    = 4'd9,
      S_BLOCK     = 4'd10
   } state_t;

   localparam logic [2:0] GS_FIGHT = 3'd2;

   state_t     state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic       pending_q, pending_d;
   logic       hit_window_q, hit_window_d;
   logic       busy_q, busy_d;
   logic       block_used_q, block_used_d;
   logic       hit_blocked_q, hit_blocked_d;

   state_t     sel_state;
   logic       hit_now;
   logic       took_sel;

   // A state lasts T ticks, so its counter starts at T-1. The tick that
   // finds the counter at zero is the tick that leaves the state. Untimed
   // states keep the counter at zero.
   function automatic logic [4:0] load_value(input state_t s);
      logic [4:0] v;
      v = 5'd0;
      case (s)
         S_ATK_START: v = 5'(T_ATK_START - 1);
         S_ATK_END:   v = 5'(T_ATK_END - 1);
         S_ATK_PULL:  v = 5'(T_ATK_PULL - 1);
         S_DIR_START: v = 5'(T_DIR_START - 1);
         S_DIR_END:   v = 5'(T_DIR_END - 1);
         S_DIR_PULL:  v = 5'(T_DIR_PULL - 1);
         S_GOTHIT:    v = 5'(T_HIT - 1);
         S_BLOCK:     v = 5'(T_BLOCK - 1);
         default:     v = 5'd0;
      endcase
      return v;
   endfunction

   // The untimed selection reads only the current request levels. Nothing
   // is remembered from requests made during a timed state. A block request
   // with no charges left falls through to the movement checks.
   always_comb begin
      sel_state = S_IDLE;
      if (act_attack)
         sel_state = S_ATK_START;
      else if (act_dir)
         sel_state = S_DIR_START;
      else if (act_block && block_avail)
         sel_state = S_BLOCK;
      else if (act_fwd && !act_back)
         sel_state = S_WALK;
      else if (act_back && !act_fwd)
         sel_state = S_WALKBACK;
   end

   // Next-state decision. Between ticks the only thing that moves is the
   // pending-hit flag. A hit that arrives in the same cycle as the tick
   // counts at that tick, so the effective hit is the flag ORed with the
   // live pulse. At a tick, leaving the fight wins over everything else.
   // A hit comes next: it either stuns the player or is absorbed by BLOCK.
   // Absorbing a hit still lets the block countdown run, so the block keeps
   // its normal length.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pending_d     = pending_q | got_hit;
      block_used_d  = 1'b0;
      hit_blocked_d = 1'b0;
      took_sel      = 1'b0;
      hit_now       = pending_q | got_hit;

      if (frame_tick) begin
         pending_d = 1'b0;
         if (game_state != GS_FIGHT) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
         end else if (hit_now && state_q != S_BLOCK) begin
            state_d = S_GOTHIT;
            cnt_d   = load_value(S_GOTHIT);
         end else if (hit_now) begin
            hit_blocked_d = 1'b1;
            if (cnt_q != 5'd0)
               cnt_d = cnt_q - 5'd1;
         end else begin
            case (state_q)
               S_IDLE, S_WALK, S_WALKBACK: begin
                  state_d  = sel_state;
                  took_sel = 1'b1;
               end
               default: begin
                  if (cnt_q != 5'd0) begin
                     cnt_d = cnt_q - 5'd1;
                  end else begin
                     case (state_q)
                        S_ATK_START: state_d = S_ATK_END;
                        S_ATK_END:   state_d = S_ATK_PULL;
                        S_DIR_START: state_d = S_DIR_END;
                        S_DIR_END:   state_d = S_DIR_PULL;
                        default: begin
                           state_d  = sel_state;
                           took_sel = 1'b1;
                        end
                     endcase
                     cnt_d = load_value(state_d);
                  end
               end
            endcase
            if (took_sel) begin
               cnt_d        = load_value(sel_state);
               block_used_d = (sel_state == S_BLOCK);
            end
         end
      end

      hit_window_d = (state_d == S_ATK_END) || (state_d == S_DIR_END);
      busy_d       = (state_d >= S_ATK_START);
   end

   // All state and every output sit in one register bank. The outputs follow
   // the same edge as the sprite code, so the renderer always sees a
   // consistent set of values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= 5'd0;
         pending_q     <= 1'b0;
         hit_window_q  <= 1'b0;
         busy_q        <= 1'b0;
         block_used_q  <= 1'b0;
         hit_blocked_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pending_q     <= pending_d;
         hit_window_q  <= hit_window_d;
         busy_q        <= busy_d;
         block_used_q  <= block_used_d;
         hit_blocked_q <= hit_blocked_d;
      end
   end

   assign sprite_state = state_q;
   assign hit_window   = hit_window_q;
   assign busy         = busy_q;
   assign block_used   = block_used_q;
   assign hit_blocked  = hit_blocked_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// ---------------------------------------------------------------------------
// tb_anim_sequencer
//
// Purpose:
//    Self-checking bench for anim_sequencer with default parameters. A
//    vector table covers untimed selection and block entry. Hand-written
//    sequences cover the attack, hit stun, directional attack, leaving the
//    fight, and asynchronous reset.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_anim_sequencer;

   logic       clk;
   logic       rst;
   logic       frame_tick;
   logic [2:0] game_state;
   logic       act_fwd, act_back, act_attack, act_dir, act_block;
   logic       block_avail;
   logic       got_hit;
   logic [3:0] sprite_state;
   logic       hit_window, busy, block_used, hit_blocked;

   int checkCount;
   int failCount;
   logic inHitSeq;
   logic sawHitWindow;

   typedef struct {
      logic [2:0] gameState;
      logic       fwd;
      logic       back;
      logic       attack;
      logic       dir;
      logic       block;
      logic       avail;
      logic       hit;
      logic [3:0] expState;
      logic       expHw;
      logic       expBusy;
      logic       expBu;
      logic       expHb;
   } vec_t;

   vec_t vecs[8];

   anim_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .frame_tick   (frame_tick),
      .game_state   (game_state),
      .act_fwd      (act_fwd),
      .act_back     (act_back),
      .act_attack   (act_attack),
      .act_dir      (act_dir),
      .act_block    (act_block),
      .block_avail  (block_avail),
      .got_hit      (got_hit),
      .sprite_state (sprite_state),
      .hit_window   (hit_window),
      .busy         (busy),
      .block_used   (block_used),
      .hit_blocked  (hit_blocked)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record any hit_window assertion during the hit-stun sequence. The
   // attack was preempted before it reached ATK_END, so none is expected.
   always @(posedge clk) begin
      if (inHitSeq && hit_window)
         sawHitWindow <= 1'b1;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // One frame tick: raise frame_tick for one cycle, optionally with a
   // coincident got_hit. Returns at the following falling edge, once the
   // outputs reflect the tick.
   task automatic applyTick(input logic hitWithTick);
      @(negedge clk);
      frame_tick = 1'b1;
      got_hit    = hitWithTick;
      @(negedge clk);
      frame_tick = 1'b0;
      got_hit    = 1'b0;
   endtask

   task automatic pulseHit();
      @(negedge clk);
      got_hit = 1'b1;
      @(negedge clk);
      got_hit = 1'b0;
   endtask

   task automatic setActs(input logic f, input logic b, input logic a,
                          input logic d, input logic k, input logic av);
      act_fwd     = f;
      act_back    = b;
      act_attack  = a;
      act_dir     = d;
      act_block   = k;
      block_avail = av;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] expState,
                              input logic expHw, input logic expBusy,
                              input logic expBu, input logic expHb);
      logic [7:0] act, exp;
      act = {sprite_state, hit_window, busy, block_used, hit_blocked};
      exp = {expState, expHw, expBusy, expBu, expHb};
      checkCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got state=%0d hw=%b busy=%b bu=%b hb=%b, want state=%0d hw=%b busy=%b bu=%b hb=%b",
                  name, sprite_state, hit_window, busy, block_used, hit_blocked,
                  expState, expHw, expBusy, expBu, expHb);
      end
   endtask

   // Apply one table vector. If the vector asks for a hit, pulse got_hit a
   // few cycles before the tick so it has to be held as pending.
   task automatic applyStimulus(input vec_t v, input int idx);
      game_state = v.gameState;
      setActs(v.fwd, v.back, v.attack, v.dir, v.block, v.avail);
      if (v.hit)
         pulseHit();
      repeat (2) @(negedge clk);
      applyTick(1'b0);
      checkOutput($sformatf("vec%0d", idx), v.expState, v.expHw, v.expBusy,
                  v.expBu, v.expHb);
   endtask

   initial begin
      checkCount   = 0;
      failCount    = 0;
      inHitSeq     = 1'b0;
      sawHitWindow = 1'b0;
      rst          = 1'b1;
      frame_tick   = 1'b0;
      got_hit      = 1'b0;
      game_state   = 3'd2;
      setActs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      //            gs    fwd   back  atk   dir   blk   avail hit   state  hw    busy  bu    hb
      vecs[0] = '{3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd10, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      checkOutput("reset_state", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("after_release", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Table: movement selection, ignored block, not fighting, and block
      // entry followed by an absorbed hit (block ticks 1..3).
      for (int i = 0; i < 8; i++)
         applyStimulus(vecs[i], i);

      // Block ticks 4..10 stay in BLOCK; tick 11 exits to selection.
      for (int t = 4; t <= 10; t++) begin
         applyTick(1'b0);
         checkOutput($sformatf("block_t%0d", t), 4'd10, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      applyTick(1'b0);
      checkOutput("block_exit", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Attack held for one tick, together with act_dir to test priority.
      // Expected: 3 x5, 4 x2 (hit_window), 5 x8, then idle.
      setActs(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int t = 1; t <= 16; t++) begin
         logic [3:0] es;
         applyTick(1'b0);
         if (t == 1)
            setActs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (t <= 5)       es = 4'd3;
         else if (t <= 7)  es = 4'd4;
         else if (t <= 15) es = 4'd5;
         else              es = 4'd0;
         checkOutput($sformatf("atk_t%0d", t), es, (es == 4'd4), (es != 4'd0),
                     1'b0, 1'b0);
      end

      // Hit during ATK_START, pulsed 10 cycles before the tick. Then a
      // second hit coincident with a tick restarts the stun.
      inHitSeq = 1'b1;
      setActs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyTick(1'b0);
      setActs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("hit_atk_start", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      pulseHit();
      repeat (9) @(negedge clk);
      checkOutput("hit_no_tick_yet", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int t = 1; t <= 5; t++) begin
         applyTick(1'b0);
         checkOutput($sformatf("stun_t%0d", t), 4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      applyTick(1'b1);
      checkOutput("stun_restart", 4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int t = 2; t <= 16; t++) begin
         applyTick(1'b0);
         checkOutput($sformatf("restun_t%0d", t), (t <= 15) ? 4'd9 : 4'd0,
                     1'b0, (t <= 15), 1'b0, 1'b0);
      end
      inHitSeq = 1'b0;
      checkCount++;
      if (sawHitWindow !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL stun_no_hit_window: got %b, want 0", sawHitWindow);
      end

      // Directional attack reaches DIR_END, then the game leaves FIGHT.
      setActs(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int t = 1; t <= 5; t++) begin
         applyTick(1'b0);
         if (t == 1)
            setActs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("dir_t%0d", t), (t <= 4) ? 4'd6 : 4'd7,
                     (t == 5), 1'b1, 1'b0, 1'b0);
      end
      game_state = 3'd3;
      applyTick(1'b0);
      checkOutput("win_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      setActs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyTick(1'b0);
      checkOutput("win_ignore_act", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      game_state = 3'd2;
      setActs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyTick(1'b0);
      checkOutput("fight_again", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset between ticks while in GOTHIT.
      pulseHit();
      applyTick(1'b0);
      checkOutput("pre_reset_stun", 4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 checkOutput("async_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("no_tick_hold", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyTick(1'b0);
      checkOutput("post_reset_select", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
